// File: rtl/sd_arb_pkg.sv
// sd_req_arbiter shared types: FSM states, grant width, transfer directions.
// Used by the arbiter top and its round-robin picker.
package sd_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int GW      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [GW-1:0] i);
        return MAX_REQ'(1) << i;
    endfunction

endpackage

// File: rtl/sd_req_arbiter_rr_pick.sv
// Combinational round-robin picker for sd_req_arbiter.
// Finds the first pending client searching upward from last+1 with wrap.
module rr_pick
    import sd_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] pending,
    input  logic [GW-1:0]   last,
    output logic            valid,
    output logic [GW-1:0]   idx
);

    logic [MAX_REQ-1:0] pend;

    assign pend = MAX_REQ'(pending);

    // Scan farthest offset first so the nearest pending client after last wins
    always_comb begin
        logic [GW-1:0] j;
        valid = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = GW'((int'(last) + k) % NREQ);
            if (pend[j]) begin
                valid = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing one HPS SD block channel among NREQ disk clients.
// Optional issue timeout is enabled by defining SD_ARB_TIMEOUT_EN.
module sd_req_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int AW      = 9,
    parameter int TIMEOUT = 1 << 24
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [32*NREQ-1:0]   req_lba,
    input  logic [NREQ-1:0]      req_rd,
    input  logic [NREQ-1:0]      req_wr,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      req_err,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      req_buff_wr,
    input  logic [DW*NREQ-1:0]   req_buff_din,
    output logic [AW-1:0]        buff_addr,
    output logic [DW-1:0]        buff_dout,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    input  logic [AW-1:0]        sd_buff_addr,
    input  logic [DW-1:0]        sd_buff_dout,
    input  logic                 sd_buff_wr,
    output logic [DW-1:0]        sd_buff_din,
    output logic [GW-1:0]        grant,
    output logic                 busy
);

    state_t             state, state_nxt;
    logic [GW-1:0]      grant_q, grant_nxt;
    logic [GW-1:0]      last_q, last_nxt;
    logic [31:0]        lba_q, lba_nxt;
    logic               rd_q, rd_nxt;
    logic               wr_q, wr_nxt;
    logic [NREQ-1:0]    done_q, done_nxt;
    logic               busy_q, busy_nxt;

    logic               pick_valid;
    logic [GW-1:0]      pick_idx;
    logic               pick_dir;
    logic               act;

    logic [31:0]        lba_arr [MAX_REQ];
    logic [DW-1:0]      din_arr [MAX_REQ];
    logic [MAX_REQ-1:0] rd_vec;

    assign rd_vec = MAX_REQ'(req_rd);

    for (genvar i = 0; i < MAX_REQ; i++) begin : g_arr
        if (i < NREQ) begin : g_used
            assign lba_arr[i] = req_lba[32*i +: 32];
            assign din_arr[i] = req_buff_din[DW*i +: DW];
        end else begin : g_pad
            assign lba_arr[i] = '0;
            assign din_arr[i] = '0;
        end
    end

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .pending (req_rd | req_wr),
        .last    (last_q),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    // Read wins when a client raises both; its write stays pending
    assign pick_dir = rd_vec[pick_idx] ? DIR_RD : DIR_WR;

    // Strobes reach a client only while its transfer is live, so spurious
    // sd_ack in IDLE or DONE produces nothing
    assign act = busy_q & ((state == ISSUE) | (state == XFER));

    for (genvar i = 0; i < NREQ; i++) begin : g_route
        assign req_ack[i]     = sd_ack & act & (grant_q == GW'(i));
        assign req_buff_wr[i] = sd_buff_wr & act & (grant_q == GW'(i));
    end

    assign sd_buff_din = din_arr[grant_q];
    assign buff_addr   = sd_buff_addr;
    assign buff_dout   = sd_buff_dout;

    assign sd_lba   = lba_q;
    assign sd_rd    = rd_q;
    assign sd_wr    = wr_q;
    assign req_done = done_q;
    assign grant    = grant_q;
    assign busy     = busy_q;

`ifdef SD_ARB_TIMEOUT_EN
    localparam logic [24:0] TO_LAST = 25'(TIMEOUT - 1);

    logic [24:0]     cnt_q, cnt_nxt;
    logic [NREQ-1:0] err_q, err_nxt;

    assign req_err = err_q;

    // Issue watchdog counter and error pulse register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
            err_q <= err_nxt;
        end
    end
`else
    assign req_err = '0;
`endif

    // Control state and registered outputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state   <= IDLE;
            grant_q <= '0;
            last_q  <= '0;
            lba_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            last_q  <= last_nxt;
            lba_q   <= lba_nxt;
            rd_q    <= rd_nxt;
            wr_q    <= wr_nxt;
            done_q  <= done_nxt;
            busy_q  <= busy_nxt;
        end
    end

    // Next-state and next-output logic for one transaction at a time
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        last_nxt  = last_q;
        lba_nxt   = lba_q;
        rd_nxt    = rd_q;
        wr_nxt    = wr_q;
        done_nxt  = '0;
`ifdef SD_ARB_TIMEOUT_EN
        cnt_nxt   = cnt_q;
        err_nxt   = '0;
`endif
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_nxt = pick_idx;
                    lba_nxt   = lba_arr[pick_idx];
                    rd_nxt    = (pick_dir == DIR_RD);
                    wr_nxt    = (pick_dir == DIR_WR);
                    state_nxt = ISSUE;
`ifdef SD_ARB_TIMEOUT_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            ISSUE: begin
                if (sd_ack) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    state_nxt = XFER;
`ifdef SD_ARB_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    err_nxt   = NREQ'(onehot(grant_q));
                    last_nxt  = grant_q;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt   = cnt_q + 25'd1;
`endif
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    done_nxt  = NREQ'(onehot(grant_q));
                    last_nxt  = grant_q;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule
